lc_instr_sequencer: RTL
=======================

# lc_instr_sequencer

Control block in front of the HLS layout-convert core. It fetches layout-convert instructions from the instruction FIFO one at a time and hands each to the core through a FIFO-style read port. It gates the pe2lc data handshake so the core receives exactly the beat count the instruction declares. It then tracks lc2res output beats to detect completion and protocol errors, so the core never runs more than one instruction ahead of the data.

## Interface
Parameters:
- CORE_INSTR_WIDTH, 64, instruction width (≥64)
- CNT_WIDTH, 16, width of beat-count fields

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- ap_start  in  1  start request; latched sticky into start_r until reset
- s_instr_tvalid  in  1  instruction FIFO valid
- s_instr_tready  out  1  instruction pop
- s_instr_tdata  in  CORE_INSTR_WIDTH  instruction word
- core_instr_dout  out  CORE_INSTR_WIDTH  instruction presented to core
- core_instr_empty_n  out  1  instruction available to core
- core_instr_read  in  1  core consumes instruction
- pe_tvalid_i  in  1  upstream pe2lc valid
- pe_tready_o  out  1  gated ready to upstream
- core_pe_tvalid  out  1  gated valid to core
- core_pe_tready  in  1  core pe2lc ready
- res_tvalid  in  1  lc2res valid (monitor)
- res_tready  in  1  lc2res ready (monitor)
- res_tlast  in  1  lc2res last (monitor)
- busy  out  1  high outside IDLE/HALT
- done  out  1  one-cycle pulse per completed instruction
- halted  out  1  end-of-program instruction seen
- err  out  1  sticky tlast-position error
- instr_cnt  out  32  completed instructions

## Operation
- Instruction fields: [CNT_WIDTH-1:0] = pe2lc beats − 1 (IN_M1); [2·CNT_WIDTH-1:CNT_WIDTH] = lc2res beats − 1 (OUT_M1); [63:60] = opcode, where 0xF = end-of-program and any other value = convert.
- FSM states: IDLE, LOAD, ISSUE, RUN, DONE, HALT.
- IDLE: s_instr_tready = start_r. On s_instr_tvalid & s_instr_tready, register the word → LOAD.
- LOAD: if opcode = 0xF → HALT. Otherwise load in_rem = IN_M1+1 and out_rem = OUT_M1+1 (CNT_WIDTH+1 bits, no overflow) → ISSUE.
- ISSUE: core_instr_empty_n = 1 and core_instr_dout = the registered word. On core_instr_read → RUN.
- RUN:
  - pe gate open iff in_rem ≠ 0. Then core_pe_tvalid = pe_tvalid_i and pe_tready_o = core_pe_tready; otherwise both are 0.
  - Each gated handshake decrements in_rem.
  - Each res_tvalid & res_tready decrements out_rem.
  - On the beat where out_rem = 1: if res_tlast = 0, set err. On any beat with res_tlast = 1 and out_rem > 1, also set err.
  - When out_rem reaches 0 and in_rem = 0 → DONE. If out_rem reaches 0 while in_rem ≠ 0, stay in RUN until in_rem = 0.
  - Output beats that arrive while out_rem = 0 set err and are not counted.
- DONE: pulse done, increment instr_cnt (wraps at 2^32) → IDLE.
- HALT: halted = 1, s_instr_tready = 0, gates closed. Exit only by reset.
- pe gate is closed in every state except RUN.

## Timing
- Reset (asynchronous, immediate) values: s_instr_tready = 0, core_instr_empty_n = 0, core_instr_dout = 0, pe_tready_o = 0, core_pe_tvalid = 0, busy = 0, done = 0, halted = 0, err = 0, instr_cnt = 0, start_r = 0, state = IDLE.
- Reset mid-RUN aborts the instruction; no done pulse is issued.
- s_instr_tready depends on state and start_r only (registered). Gate outputs are combinational from in_rem/state and the passed-through valid/ready.
- Latency: fetch handshake → core_instr_empty_n high 2 cycles later (LOAD, then ISSUE).
- Final counted beat → done pulse on the next cycle. Next fetch possible 1 cycle after done.
- An input beat and an output beat in the same cycle both count.
- ap_start arriving in the same cycle as s_instr_tvalid: fetch occurs the following cycle.

## Test plan
- Basic: ap_start, instr IN_M1 = 3, OUT_M1 = 1, opcode 0 → core sees the word; exactly 4 pe beats pass, the 5th is blocked (pe_tready_o = 0); 2 res beats with tlast on the 2nd → done pulse, instr_cnt = 1, err = 0.
- Back-to-back: 3 queued instructions with continuous data → 3 done pulses, instr_cnt = 3, never two instructions in RUN at once.
- tlast error: OUT_M1 = 2 with tlast on beat 2 → err = 1 (sticky), done still pulses after beat 3.
- Output before input finishes: out_rem hits 0 while in_rem = 2 → remains RUN; done only after 2 more pe beats.
- End-of-program: opcode 0xF after one convert → halted = 1, s_instr_tready stays 0 with tvalid held high for 20 cycles.
- Reset mid-RUN after 2 of 4 pe beats → all outputs at reset values in the same cycle; a fresh instruction then runs normally.

Source files
------------

// File: rtl/lc_instr_sequencer.sv
// Instruction sequencer for the layout-convert core: fetches one instruction at a time,
// meters pe2lc input beats and watches lc2res output beats for completion and tlast errors.
module lc_instr_sequencer #(
  parameter int CORE_INSTR_WIDTH = 64,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ap_start,
  input  logic                        s_instr_tvalid,
  output logic                        s_instr_tready,
  input  logic [CORE_INSTR_WIDTH-1:0] s_instr_tdata,
  output logic [CORE_INSTR_WIDTH-1:0] core_instr_dout,
  output logic                        core_instr_empty_n,
  input  logic                        core_instr_read,
  input  logic                        pe_tvalid_i,
  output logic                        pe_tready_o,
  output logic                        core_pe_tvalid,
  input  logic                        core_pe_tready,
  input  logic                        res_tvalid,
  input  logic                        res_tready,
  input  logic                        res_tlast,
  output logic                        busy,
  output logic                        done,
  output logic                        halted,
  output logic                        err,
  output logic [31:0]                 instr_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_RUN, S_DONE, S_HALT} state_t;

  localparam logic [3:0]           OP_EOP  = 4'hF;
  localparam logic [CNT_WIDTH:0]   REM_ONE = {{CNT_WIDTH{1'b0}}, 1'b1};

  state_t                      state, state_nxt;
  logic                        start_r;
  logic [CORE_INSTR_WIDTH-1:0] instr_q;
  logic [CNT_WIDTH:0]          in_rem, out_rem;
  logic [CNT_WIDTH:0]          in_rem_nxt, out_rem_nxt;
  logic                        fetch, gate_open, in_beat, out_beat, out_cnt, err_hit;
  logic [3:0]                  opcode;

  assign opcode    = instr_q[63:60];
  assign fetch     = (state == S_IDLE) && start_r && s_instr_tvalid;
  assign gate_open = (state == S_RUN) && (in_rem != '0);
  assign in_beat   = gate_open && pe_tvalid_i && core_pe_tready;
  assign out_beat  = (state == S_RUN) && res_tvalid && res_tready;
  assign out_cnt   = out_beat && (out_rem != '0);

  // Beats past the declared count, a missing tlast on the final beat, or an early tlast.
  assign err_hit = out_beat && ((out_rem == '0) ||
                                ((out_rem == REM_ONE) && !res_tlast) ||
                                ((out_rem >  REM_ONE) &&  res_tlast));

  assign in_rem_nxt  = in_beat ? in_rem  - REM_ONE : in_rem;
  assign out_rem_nxt = out_cnt ? out_rem - REM_ONE : out_rem;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case, otherwise unlisted paths infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (fetch) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = (opcode == OP_EOP) ? S_HALT : S_ISSUE;
      S_ISSUE: if (core_instr_read) state_nxt = S_RUN;
      S_RUN:   if ((in_rem_nxt == '0) && (out_rem_nxt == '0)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    s_instr_tready     = 1'b0;
    core_instr_empty_n = 1'b0;
    core_instr_dout    = '0;
    busy               = 1'b1;
    done               = 1'b0;
    halted             = 1'b0;
    unique case (state)
      S_IDLE: begin
        s_instr_tready = start_r;
        busy           = 1'b0;
      end
      S_ISSUE: begin
        core_instr_empty_n = 1'b1;
        core_instr_dout    = instr_q;
      end
      S_DONE: done = 1'b1;
      S_HALT: begin
        halted = 1'b1;
        busy   = 1'b0;
      end
      default: ;
    endcase
  end

  assign core_pe_tvalid = gate_open && pe_tvalid_i;
  assign pe_tready_o    = gate_open && core_pe_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_r   <= 1'b0;
      instr_q   <= '0;
      in_rem    <= '0;
      out_rem   <= '0;
      err       <= 1'b0;
      instr_cnt <= '0;
    end else begin
      if (ap_start) start_r <= 1'b1;
      if (fetch)    instr_q <= s_instr_tdata;
      if (state == S_LOAD) begin
        in_rem  <= {1'b0, instr_q[CNT_WIDTH-1:0]} + REM_ONE;
        out_rem <= {1'b0, instr_q[2*CNT_WIDTH-1:CNT_WIDTH]} + REM_ONE;
      end else if (state == S_RUN) begin
        in_rem  <= in_rem_nxt;
        out_rem <= out_rem_nxt;
      end
      if (err_hit)          err       <= 1'b1;
      if (state == S_DONE)  instr_cnt <= instr_cnt + 32'd1;
    end
  end

endmodule
